// File: rtl/pac_man_pkg.sv
// Shared types and tile-geometry helpers for the Pac-Man movement controller.
package pac_man_pkg;

   localparam int GRID_W = 32;
   localparam int GRID_H = 32;
   localparam int ADDR_W = 10;
   localparam int COL_W  = $clog2(GRID_W);
   localparam int ROW_W  = ADDR_W - COL_W;

   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(GRID_W - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(GRID_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(GRID_W);

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_Q_DES,
      S_W_DES,
      S_Q_CUR,
      S_W_CUR,
      S_ISSUE
   } move_state_t;

   // Candidate tile one step from curr; wraps mod 2^ADDR_W, so edge legality
   // must be checked separately with off_grid().
   function automatic logic [ADDR_W-1:0] next_tile(input logic [ADDR_W-1:0] curr,
                                                   input dir_t dir);
      logic [ADDR_W-1:0] nxt;
      nxt = curr;
      case (dir)
         DIR_UP:    nxt = curr - ROW_STEP;
         DIR_DOWN:  nxt = curr + ROW_STEP;
         DIR_LEFT:  nxt = curr - ADDR_W'(1);
         DIR_RIGHT: nxt = curr + ADDR_W'(1);
         default:   nxt = curr;
      endcase
      return nxt;
   endfunction

   function automatic logic off_grid(input logic [ADDR_W-1:0] curr,
                                     input dir_t dir);
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic             off;
      col = curr[COL_W-1:0];
      row = curr[ADDR_W-1:COL_W];
      off = 1'b0;
      case (dir)
         DIR_UP:    off = (row == '0);
         DIR_DOWN:  off = (row == ROW_MAX);
         DIR_LEFT:  off = (col == '0);
         DIR_RIGHT: off = (col == COL_MAX);
         default:   off = 1'b0;
      endcase
      return off;
   endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Free-running move pacer: one-cycle tick every TICK_DIV clocks.
module move_tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int                CNT_W   = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pac_man_move_ctrl.sv
// Issues legal one-hot moves and a canMove strobe to pac_man_behavior,
// validating each candidate tile against the 1-cycle-latency wall ROM.
module pac_man_move_ctrl
   import pac_man_pkg::*;
#(
   parameter int TICK_DIV = 5000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_up,
   input  logic              key_down,
   input  logic              key_left,
   input  logic              key_right,
   input  logic [ADDR_W-1:0] curr_block,
   output logic [ADDR_W-1:0] wall_addr,
   input  logic              wall_data,
   output logic              up,
   output logic              down,
   output logic              left,
   output logic              right,
   output logic              canMove
);

   logic              tick;
   move_state_t       state_q, state_d;
   dir_t              desired_q, desired_d;
   dir_t              cur_q, cur_d;
   dir_t              try_q, try_d;
   logic [ADDR_W-1:0] wall_addr_q, wall_addr_d;
   logic [3:0]        dir_lv_q, dir_lv_d;
   logic              can_move_q, can_move_d;
   logic              addr_drive;
   logic [ADDR_W-1:0] addr_cand;

   move_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Only an unambiguous single key updates the request; chords are ignored.
   always_comb begin
      desired_d = desired_q;
      case ({key_up, key_down, key_left, key_right})
         4'b1000: desired_d = DIR_UP;
         4'b0100: desired_d = DIR_DOWN;
         4'b0010: desired_d = DIR_LEFT;
         4'b0001: desired_d = DIR_RIGHT;
         default: desired_d = desired_q;
      endcase
   end

   // try_q snapshots the direction whose tile was sent to the ROM, so the
   // adopted direction always matches the tile that was actually checked.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      try_d      = try_q;
      addr_drive = 1'b0;
      addr_cand  = '0;
      case (state_q)
         S_IDLE: begin
            if (tick) begin
               state_d = S_Q_DES;
            end
         end
         S_Q_DES: begin
            if (desired_q == DIR_NONE || off_grid(curr_block, desired_q)) begin
               state_d = S_Q_CUR;
            end else begin
               addr_drive = 1'b1;
               addr_cand  = next_tile(curr_block, desired_q);
               try_d      = desired_q;
               state_d    = S_W_DES;
            end
         end
         S_W_DES: begin
            if (!wall_data) begin
               cur_d   = try_q;
               state_d = S_ISSUE;
            end else begin
               state_d = S_Q_CUR;
            end
         end
         S_Q_CUR: begin
            if (cur_q == DIR_NONE || off_grid(curr_block, cur_q)) begin
               cur_d   = DIR_NONE;
               state_d = S_IDLE;
            end else begin
               addr_drive = 1'b1;
               addr_cand  = next_tile(curr_block, cur_q);
               state_d    = S_W_CUR;
            end
         end
         S_W_CUR: begin
            if (!wall_data) begin
               state_d = S_ISSUE;
            end else begin
               cur_d   = DIR_NONE;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The ROM samples the address in the query cycle, so it is presented
   // combinationally there and held from the register otherwise.
   always_comb begin
      wall_addr   = addr_drive ? addr_cand : wall_addr_q;
      wall_addr_d = wall_addr;
      can_move_d  = (state_d == S_ISSUE);
      dir_lv_d    = 4'b0000;
      case (cur_d)
         DIR_UP:    dir_lv_d = 4'b1000;
         DIR_DOWN:  dir_lv_d = 4'b0100;
         DIR_LEFT:  dir_lv_d = 4'b0010;
         DIR_RIGHT: dir_lv_d = 4'b0001;
         default:   dir_lv_d = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         desired_q   <= DIR_NONE;
         cur_q       <= DIR_NONE;
         try_q       <= DIR_NONE;
         wall_addr_q <= '0;
         dir_lv_q    <= 4'b0000;
         can_move_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         desired_q   <= desired_d;
         cur_q       <= cur_d;
         try_q       <= try_d;
         wall_addr_q <= wall_addr_d;
         dir_lv_q    <= dir_lv_d;
         can_move_q  <= can_move_d;
      end
   end

   assign {up, down, left, right} = dir_lv_q;
   assign canMove                 = can_move_q;

endmodule
